bus_arbiter: RTL

- Shares the core's single memory bus between instruction fetch (master 0, IF) and load/store (master 1, MEM).
- Latches each granted request, runs the req/ack handshake with the slave, and returns the response to the owning master.
- Generates stallreq_from_if / stallreq_from_mem for the pipeline stall controller.
- On a taken branch, drains a wrong-path fetch, and bounds every transaction with a timeout.

---
 rtl/bus_arbiter_if.sv | 21 ++
 rtl/bus_arbiter.sv | 95 +++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: memory bus between the arbiter (master) and the shared slave.
interface bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          bus_req_o;
  logic          bus_we_o;
  logic [3:0]    bus_sel_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_ack_i;
  modport master (
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    input  bus_rdata_i, bus_ack_i
  );
  modport slave (
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between fetch (IF) and load/store (MEM)
// with MEM-burst fairness, wrong-path fetch draining and a transaction timeout.
module bus_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int TIMEOUT       = 255,
  parameter int MEM_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          mem_req_i,
  input  logic          mem_we_i,
  input  logic [3:0]    mem_sel_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic [DW-1:0] mem_rdata_o,
  output logic          mem_ack_o,
  input  logic          branch_flag_i,
  bus_arbiter_if.master bus,
  output logic          stallreq_from_if,
  output logic          stallreq_from_mem,
  output logic          bus_err_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(MEM_BURST_MAX + 1);
  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM, DRAIN} state_t;
  state_t        st, nxt;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    sel_q;
  logic          we_q;
  logic          busy, ack, to, done, take_mem, take_if;
  assign busy     = st != IDLE;
  assign ack      = bus.bus_ack_i;
  assign to       = busy & ~ack & (tcnt == TW'(TIMEOUT - 1));
  assign done     = ack | to;
  assign take_mem = (st == IDLE) & mem_req_i & ((bcnt < BW'(MEM_BURST_MAX)) | ~if_req_i);
  assign take_if  = (st == IDLE) & ~take_mem & if_req_i & ~branch_flag_i;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = take_mem ? GNT_MEM : take_if ? GNT_IF : IDLE;
      GNT_MEM: nxt = done ? IDLE : GNT_MEM;
      GNT_IF:  nxt = done ? IDLE : branch_flag_i ? DRAIN : GNT_IF;
      default: nxt = done ? IDLE : DRAIN;
    endcase
  end
  // A branch in GNT_IF cancels the fetch; DRAIN never acks anyone.
  assign if_ack_o          = (st == GNT_IF) & done & ~branch_flag_i;
  assign mem_ack_o         = (st == GNT_MEM) & done;
  assign if_rdata_o        = ((st == GNT_IF) & ack) ? bus.bus_rdata_i : '0;
  assign mem_rdata_o       = ((st == GNT_MEM) & ack) ? bus.bus_rdata_i : '0;
  assign bus_err_o         = to;
  assign stallreq_from_if  = rst & if_req_i & ~if_ack_o & ~branch_flag_i;
  assign stallreq_from_mem = rst & mem_req_i & ~mem_ack_o;
  assign bus.bus_req_o     = busy;
  assign bus.bus_we_o      = we_q;
  assign bus.bus_sel_o     = sel_q;
  assign bus.bus_addr_o    = addr_q;
  assign bus.bus_wdata_o   = wdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      st   <= nxt;
      tcnt <= busy ? tcnt + TW'(1) : '0;
      if (take_mem) begin
        addr_q  <= mem_addr_i;
        wdata_q <= mem_wdata_i;
        sel_q   <= mem_sel_i;
        we_q    <= mem_we_i;
        bcnt    <= !if_req_i ? '0 : (bcnt == BW'(MEM_BURST_MAX)) ? bcnt : bcnt + BW'(1);
      end
      if (take_if) begin
        addr_q  <= if_addr_i;
        wdata_q <= '0;
        sel_q   <= 4'hF;
        we_q    <= 1'b0;
        bcnt    <= '0;
      end
    end
  end
endmodule
